// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// ready handshakes, internal branch resolution and sticky trap reporting.
module multicycle_control_unit #(
  parameter int unsigned ENABLE_M    = 0,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WAIT_CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  imm_sel,
  output logic        br_un,
  output logic        a_sel,
  output logic        b_sel,
  output logic [3:0]  alu_sel,
  output logic        mem_rw,
  output logic        reg_wen,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP
  } cls_t;

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_illegal;
  logic                  r_bus_err;
  cls_t                  r_cls;
  logic [2:0]            r_br_f3;
  logic [2:0]            r_imm_sel;
  logic                  r_br_un;
  logic                  r_a_sel;
  logic                  r_b_sel;
  logic [3:0]            r_alu_sel;
  logic                  r_mem_rw;
  logic [1:0]            r_wb_sel;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_legal;
  cls_t       w_cls;
  logic [2:0] w_imm_sel;
  logic       w_br_un;
  logic       w_a_sel;
  logic       w_b_sel;
  logic [3:0] w_alu_sel;
  logic       w_mem_rw;
  logic [1:0] w_wb_sel;
  logic       w_taken;
  logic       w_unused_fields;

  assign w_opcode        = instr[6:0];
  assign w_funct3        = instr[14:12];
  assign w_funct7        = instr[31:25];
  assign w_unused_fields = ^{instr[24:15], instr[11:7]};

  // Instruction decode into the control word latched in DECODE
  always_comb begin
    w_legal   = 1'b1;
    w_cls     = C_ALU;
    w_imm_sel = 3'd0;
    w_br_un   = 1'b0;
    w_a_sel   = 1'b0;
    w_b_sel   = 1'b0;
    w_alu_sel = 4'd0;
    w_mem_rw  = 1'b0;
    w_wb_sel  = 2'd1;
    case (w_opcode)
      7'b0110011: begin
        case (w_funct7)
          7'b0000000: begin
            case (w_funct3)
              3'b000:  w_alu_sel = 4'd0;
              3'b001:  w_alu_sel = 4'd2;
              3'b010:  w_alu_sel = 4'd3;
              3'b011:  w_alu_sel = 4'd4;
              3'b100:  w_alu_sel = 4'd5;
              3'b101:  w_alu_sel = 4'd6;
              3'b110:  w_alu_sel = 4'd8;
              default: w_alu_sel = 4'd9;
            endcase
          end
          7'b0100000: begin
            if (w_funct3 == 3'b000)      w_alu_sel = 4'd1;
            else if (w_funct3 == 3'b101) w_alu_sel = 4'd7;
            else                         w_legal   = 1'b0;
          end
          7'b0000001: begin
            if (ENABLE_M != 0 && w_funct3 == 3'b000) w_alu_sel = 4'd11;
            else                                     w_legal   = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        w_b_sel = 1'b1;
        case (w_funct3)
          3'b000: w_alu_sel = 4'd0;
          3'b010: w_alu_sel = 4'd3;
          3'b011: w_alu_sel = 4'd4;
          3'b100: w_alu_sel = 4'd5;
          3'b110: w_alu_sel = 4'd8;
          3'b111: w_alu_sel = 4'd9;
          3'b001: begin
            if (w_funct7 == 7'b0000000) w_alu_sel = 4'd2;
            else                        w_legal   = 1'b0;
          end
          default: begin
            if (w_funct7 == 7'b0000000)      w_alu_sel = 4'd6;
            else if (w_funct7 == 7'b0100000) w_alu_sel = 4'd7;
            else                             w_legal   = 1'b0;
          end
        endcase
      end
      7'b0000011: begin
        w_legal  = (w_funct3 == 3'b010);
        w_cls    = C_LOAD;
        w_b_sel  = 1'b1;
        w_wb_sel = 2'd0;
      end
      7'b0100011: begin
        w_legal   = (w_funct3 == 3'b010);
        w_cls     = C_STORE;
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd1;
        w_mem_rw  = 1'b1;
        w_wb_sel  = 2'd0;
      end
      7'b1100011: begin
        w_legal   = (w_funct3[2:1] != 2'b01);
        w_cls     = C_BRANCH;
        w_a_sel   = 1'b1;
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd2;
        w_br_un   = w_funct3[1];
        w_wb_sel  = 2'd0;
      end
      7'b1101111: begin
        w_cls     = C_JUMP;
        w_a_sel   = 1'b1;
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd3;
        w_wb_sel  = 2'd2;
      end
      7'b1100111: begin
        w_legal   = (w_funct3 == 3'b000);
        w_cls     = C_JUMP;
        w_b_sel   = 1'b1;
        w_wb_sel  = 2'd2;
      end
      7'b0010111: begin
        w_a_sel   = 1'b1;
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd4;
      end
      7'b0110111: begin
        w_b_sel   = 1'b1;
        w_imm_sel = 3'd4;
        w_alu_sel = 4'd10;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Branch outcome from the latched funct3 and the live comparator flags
  always_comb begin
    case (r_br_f3)
      3'b000:        w_taken = br_eq;
      3'b001:        w_taken = ~br_eq;
      3'b100, 3'b110: w_taken = br_lt;
      3'b101, 3'b111: w_taken = ~br_lt;
      default:       w_taken = 1'b0;
    endcase
  end

  // Sequencer, wait counter, sticky flags and latched control word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_cls      <= C_ALU;
      r_br_f3    <= '0;
      r_imm_sel  <= '0;
      r_br_un    <= 1'b0;
      r_a_sel    <= 1'b0;
      r_b_sel    <= 1'b0;
      r_alu_sel  <= '1;
      r_mem_rw   <= 1'b0;
      r_wb_sel   <= '0;
    end else begin
      case (r_state)
        FETCH, MEM: begin
          if ((r_state == FETCH) ? imem_ready : dmem_ready) begin
            r_wait_cnt <= '0;
            if (r_state == FETCH)     r_state <= DECODE;
            else if (r_cls == C_LOAD) r_state <= WB;
            else                      r_state <= FETCH;
          end else if (r_wait_cnt == TIMEOUT_CNT) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b1;
            r_state    <= TRAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          if (w_legal) begin
            r_cls     <= w_cls;
            r_br_f3   <= w_funct3;
            r_imm_sel <= w_imm_sel;
            r_br_un   <= w_br_un;
            r_a_sel   <= w_a_sel;
            r_b_sel   <= w_b_sel;
            r_alu_sel <= w_alu_sel;
            r_mem_rw  <= w_mem_rw;
            r_wb_sel  <= w_wb_sel;
            r_state   <= EXEC;
          end else begin
            r_cls     <= C_ALU;
            r_br_f3   <= '0;
            r_imm_sel <= '0;
            r_br_un   <= 1'b0;
            r_a_sel   <= 1'b0;
            r_b_sel   <= 1'b0;
            r_alu_sel <= '1;
            r_mem_rw  <= 1'b0;
            r_wb_sel  <= '0;
            r_illegal <= 1'b1;
            r_state   <= TRAP;
          end
        end
        EXEC: begin
          case (r_cls)
            C_BRANCH:         r_state <= FETCH;
            C_LOAD, C_STORE:  r_state <= MEM;
            default:          r_state <= WB;
          endcase
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Outputs: latched control word plus per-state strobes, all forced idle in reset
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    mem_rw   = 1'b0;
    reg_wen  = 1'b0;
    imm_sel  = '0;
    br_un    = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    alu_sel  = '1;
    wb_sel   = '0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    state_o  = '0;
    if (!rst) begin
      imm_sel = r_imm_sel;
      br_un   = r_br_un;
      a_sel   = r_a_sel;
      b_sel   = r_b_sel;
      alu_sel = r_alu_sel;
      wb_sel  = r_wb_sel;
      illegal = r_illegal;
      bus_err = r_bus_err;
      state_o = r_state;
      case (r_state)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXEC: begin
          if (r_cls == C_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = w_taken;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          mem_rw   = r_mem_rw;
          pc_we    = dmem_ready && (r_cls == C_STORE);
        end
        WB: begin
          reg_wen = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = (r_cls == C_JUMP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle RV32I control decoder.
- Drives a multi-cycle datapath through FETCH/DECODE/EXEC/MEM/WB states, with ready-handshakes to instruction and data memory.
- Resolves branches internally from br_eq/br_lt, so pc_sel is final.
- Flags illegal instructions and memory timeouts by entering a sticky TRAP state.

Parameters:
- ENABLE_M, 0: 1 decodes R-type funct7=0000001 funct3=000 (mul) to alu_sel=11; 0 treats it as illegal.
- MEM_TIMEOUT, 16: maximum wait cycles in FETCH or MEM without ready before a bus error; minimum 1.
- WAIT_CNT_W, 5: width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instr  in  32  instruction register contents, valid from DECODE onward.
- br_eq  in  1  branch comparator: rs1==rs2.
- br_lt  in  1  branch comparator: rs1<rs2, signed or unsigned per br_un.
- imem_ready  in  1  instruction memory data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 = PC+4, 1 = ALU result.
- imm_sel  out  3  immediate type: 0=I, 1=S, 2=B, 3=J, 4=U.
- br_un  out  1  1 = unsigned branch compare.
- a_sel  out  1  0 = rs1, 1 = PC.
- b_sel  out  1  0 = rs2, 1 = immediate.
- alu_sel  out  4  ALU operation: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 passB, 11 mul, 15 nop.
- mem_rw  out  1  1 = write.
- reg_wen  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 = memory, 1 = ALU, 2 = PC+4.
- illegal  out  1  sticky: illegal instruction trapped.
- bus_err  out  1  sticky: memory timeout trapped.
- state_o  out  3  current state, for debug.

Behaviour:

States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Reset:
- rst high at a rising edge sets state=FETCH, wait counter=0, illegal=0, bus_err=0, and clears the latched control registers.
- While rst is high, all outputs are forced to 0, alu_sel=15, state_o=0.

FETCH:
- imem_req=1 every cycle.
- On imem_ready: ir_we=1 for that cycle only; go to DECODE next.
- Otherwise increment the wait counter. If the counter reaches MEM_TIMEOUT with imem_ready still 0: go to TRAP and set bus_err.

DECODE (one cycle):
- Decodes instr[6:0], funct3 and funct7.
- Latches imm_sel, br_un, a_sel, b_sel, alu_sel, mem_rw, wb_sel.
- Latched values are held unchanged from EXEC to the end of the instruction.
- Unsupported opcode/funct combination: go to TRAP and set illegal; no other output is asserted.

Decode table:
- R-type: a_sel=0, b_sel=0; ALU op from funct3/funct7 as the current decoder defines it.
- OP-IMM (0010011): a_sel=0, b_sel=1, imm_sel=I; srai when funct7=0100000.
- LOAD (0000011, lw only): add, imm_sel=I, wb_sel=0.
- STORE (0100011, sw only): add, imm_sel=S, mem_rw=1.
- BRANCH (1100011): beq, bne, blt, bge, bltu, bgeu; a_sel=1, b_sel=1, imm_sel=B, add; br_un=1 for bltu/bgeu. funct3 010 and 011 are illegal.
- JAL: a_sel=1, imm_sel=J, wb_sel=2.
- JALR: a_sel=0, imm_sel=I, wb_sel=2.
- AUIPC: a_sel=1, imm_sel=U, wb_sel=1.
- LUI: passB, imm_sel=U, wb_sel=1.
- instr=0x00000013 (nop) is a legal addi.

EXEC (one cycle):
- BRANCH: taken = beq:br_eq, bne:!br_eq, blt/bltu:br_lt, bge/bgeu:!br_lt. pc_we=1; pc_sel=taken. Next state FETCH.
- LOAD/STORE: go to MEM.
- All others: go to WB.

MEM:
- dmem_req=1; mem_rw held.
- On dmem_ready: LOAD goes to WB; STORE asserts pc_we=1, pc_sel=0 and goes to FETCH.
- Timeout handling is identical to FETCH.
- The wait counter clears on every state entry.

WB (one cycle):
- reg_wen=1, pc_we=1.
- pc_sel=1 for JAL/JALR, otherwise 0.
- ALU inputs are held, so the ALU result is still the jump target.
- Next state FETCH.

TRAP:
- All request and write enables are 0; remain in TRAP until rst.

Latency:
- ALU/LUI/AUIPC/JAL/JALR: 4 cycles with zero-wait memory.
- Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
- Each memory wait cycle adds 1.

Boundary and cycle rules:
- Exactly one pc_we pulse per retired instruction.
- reg_wen is never asserted outside WB; mem_rw=1 never occurs outside MEM.
- rst mid-MEM: dmem_req=0 in the reset cycle; no reg_wen or pc_we occurs.
- A ready arriving on the same cycle the counter hits MEM_TIMEOUT counts as success; no trap.

Test Plan:
1. add x3,x1,x2 (0x002081B3), both readies tied high -> states 0,1,2,4; WB cycle has reg_wen=1, wb_sel=1, alu_sel=0, pc_we=1, pc_sel=0; total 4 cycles.
2. lw (0x0000A183), dmem_ready delayed 2 cycles -> dmem_req high for 3 cycles, mem_rw=0; then WB with wb_sel=0, reg_wen=1; total 7 cycles.
3. bge (funct3=101), first with br_lt=0 then with br_lt=1 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0; br_un=0; reg_wen never asserted.
4. jal (0x008000EF) -> imm_sel=3, a_sel=1, b_sel=1; WB has wb_sel=2, reg_wen=1, pc_sel=1.
5. Opcode 0x7F; separately, mul with ENABLE_M=0 -> TRAP after DECODE, illegal=1, no pc_we; the ENABLE_M=1 build gives alu_sel=11.
6. imem_ready held 0 with MEM_TIMEOUT=4 -> TRAP after 4 wait cycles with bus_err=1. Separately, rst pulsed during MEM of sw -> dmem_req drops, state_o=0, no mem_rw asserted after reset.
